// File: rtl/lam_pkg.sv
// Shared definitions for the load/access memory unit: command field layout,
// funct3 access-size codes and the FSM state encoding.
package lam_pkg;

    // Direction bit carried in lam_control.
    localparam logic LAM_STORE = 1'b1;
    localparam logic LAM_LOAD  = 1'b0;

    // funct3 access-size codes shared by loads and stores.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // lam_control = {is_store, funct3[2:0], reg_idx[4:0]}.
    localparam int LC_W         = 9;
    localparam int LC_STORE_BIT = 8;
    localparam int LC_F3_LSB    = 5;
    localparam int LC_IDX_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WB   = 2'd2
    } lam_state_e;

    // Field extractors so the bit layout lives in one place.
    function automatic logic lc_is_store(input logic [LC_W-1:0] lc);
        return lc[LC_STORE_BIT];
    endfunction

    function automatic logic [2:0] lc_funct3(input logic [LC_W-1:0] lc);
        return lc[LC_F3_LSB +: 3];
    endfunction

    function automatic logic [4:0] lc_reg_idx(input logic [LC_W-1:0] lc);
        return lc[LC_IDX_LSB +: 5];
    endfunction

endpackage

// File: rtl/lam_align.sv
// Lane steering for the data-memory port: byte enables and replicated write
// data for stores, lane selection plus sign/zero extension for loads, and a
// flag for misaligned addresses or funct3 codes illegal for the direction.
module lam_align
    import lam_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] mem_rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ld_data_o,
    output logic        err_o
);

    // Read word shifted so the addressed byte sits in bits [7:0].
    logic [31:0] lane;
    assign lane = mem_rdata_i >> {addr_lo_i, 3'b000};

    // Decode access size into enables, write replication, load extension and legality.
    always_comb begin
        // NOTE: every output is given a default before the case so no path leaves one unassigned, which would infer a latch.
        be_o      = 4'b0000;
        wdata_o   = store_data_i;
        ld_data_o = 32'h0000_0000;
        err_o     = 1'b0;
        case (funct3_i)
            F3_B: begin
                be_o      = 4'b0001 << addr_lo_i;
                wdata_o   = {4{store_data_i[7:0]}};
                ld_data_o = {{24{lane[7]}}, lane[7:0]};
            end
            F3_H: begin
                be_o      = 4'b0011 << addr_lo_i;
                wdata_o   = {2{store_data_i[15:0]}};
                ld_data_o = {{16{lane[15]}}, lane[15:0]};
                err_o     = addr_lo_i[0];
            end
            F3_W: begin
                be_o      = 4'b1111;
                ld_data_o = mem_rdata_i;
                err_o     = (addr_lo_i != 2'b00);
            end
            F3_BU: begin
                be_o      = 4'b0001 << addr_lo_i;
                ld_data_o = {24'h00_0000, lane[7:0]};
                err_o     = (is_store_i == LAM_STORE);
            end
            F3_HU: begin
                be_o      = 4'b0011 << addr_lo_i;
                ld_data_o = {16'h0000, lane[15:0]};
                err_o     = (is_store_i == LAM_STORE) | addr_lo_i[0];
            end
            default: begin
                err_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lam_unit.sv
// Load/Access Memory unit. Accepts one load or store per lam_new strobe,
// runs a single-outstanding request/acknowledge memory access and returns
// extended load data to the register bank write port. busy stalls the
// pipeline while an access is in flight; lam_err flags rejected commands
// and accesses abandoned after TIMEOUT cycles without an acknowledge.
module lam_unit
    import lam_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lam_new,
    input  logic [8:0]        lam_control,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [31:0]       store_data,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_en,
    output logic [4:0]        wb_sel,
    output logic [31:0]       wb_data,
    output logic              lam_err
);

    // Counter is wide enough to hold TIMEOUT; the abort fires on the last
    // waiting cycle so mem_req is high for exactly TIMEOUT cycles.
    localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] TMO_MAX  = CNT_W'(TIMEOUT);

    lam_state_e        state_q;
    logic              is_store_q;
    logic [2:0]        funct3_q;
    logic [4:0]        reg_idx_q;
    logic [1:0]        addr_lo_q;
    logic [31:0]       store_data_q;
    logic [CNT_W-1:0]  tmo_cnt_q;

    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic              wb_en_q;
    logic [4:0]        wb_sel_q;
    logic [31:0]       wb_data_q;
    logic              lam_err_q;

    // In IDLE the aligner sees the incoming command so it can be validated
    // before acceptance; afterwards it sees the latched copy for load extraction.
    logic              in_idle;
    logic              al_is_store;
    logic [2:0]        al_funct3;
    logic [1:0]        al_addr_lo;
    logic [31:0]       al_store_data;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata;
    logic [31:0]       al_ld_data;
    logic              al_err;

    assign in_idle       = (state_q == ST_IDLE);
    assign al_is_store   = in_idle ? lc_is_store(lam_control) : is_store_q;
    assign al_funct3     = in_idle ? lc_funct3(lam_control)   : funct3_q;
    assign al_addr_lo    = in_idle ? alu_addr[1:0]            : addr_lo_q;
    assign al_store_data = in_idle ? store_data               : store_data_q;

    lam_align u_align (
        .is_store_i   (al_is_store),
        .funct3_i     (al_funct3),
        .addr_lo_i    (al_addr_lo),
        .store_data_i (al_store_data),
        .mem_rdata_i  (mem_rdata),
        .be_o         (al_be),
        .wdata_o      (al_wdata),
        .ld_data_o    (al_ld_data),
        .err_o        (al_err)
    );

    // Access FSM with its command latches, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            is_store_q   <= LAM_LOAD;
            funct3_q     <= 3'b000;
            reg_idx_q    <= 5'd0;
            addr_lo_q    <= 2'b00;
            store_data_q <= 32'h0000_0000;
            tmo_cnt_q    <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            wb_en_q      <= 1'b0;
            wb_sel_q     <= 5'd0;
            wb_data_q    <= 32'h0000_0000;
            lam_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the pre-edge values, independent of statement order.
            wb_en_q   <= 1'b0;
            lam_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lam_new) begin
                        is_store_q   <= lc_is_store(lam_control);
                        funct3_q     <= lc_funct3(lam_control);
                        reg_idx_q    <= lc_reg_idx(lam_control);
                        addr_lo_q    <= alu_addr[1:0];
                        store_data_q <= store_data;
                        if (al_err) begin
                            lam_err_q <= 1'b1;
                        end else begin
                            state_q     <= ST_REQ;
                            tmo_cnt_q   <= '0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= lc_is_store(lam_control);
                            mem_addr_q  <= {alu_addr[ADDR_W-1:2], 2'b00};
                            mem_be_q    <= al_be;
                            mem_wdata_q <= (lc_is_store(lam_control) == LAM_STORE) ? al_wdata : 32'h0000_0000;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        // An ack on the final waiting cycle still completes the access.
                        mem_req_q <= 1'b0;
                        if (is_store_q == LAM_STORE) begin
                            state_q <= ST_IDLE;
                        end else begin
                            state_q <= ST_WB;
                            // x0 is never written, and the write port keeps its last value.
                            if (reg_idx_q != 5'd0) begin
                                wb_en_q   <= 1'b1;
                                wb_sel_q  <= reg_idx_q;
                                wb_data_q <= al_ld_data;
                            end
                        end
                    end else if ((TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
                        mem_req_q <= 1'b0;
                        lam_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else if ((TIMEOUT != 0) && (tmo_cnt_q != TMO_MAX)) begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                ST_WB: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_sel    = wb_sel_q;
    assign wb_data   = wb_data_q;
    assign lam_err   = lam_err_q;

endmodule

// File: tb/tb_lam_unit.sv
// Self-checking bench for lam_unit: directed cases followed by random
// commands. Expected memory requests and responses are queued at issue time
// and compared by an independent monitor on the falling clock edge.
module tb_lam_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lam_new;
    logic [8:0]  lam_control;
    logic [31:0] alu_addr;
    logic [31:0] store_data;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_data;
    logic        lam_err;

    always #5 clk = ~clk;

    lam_unit #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lam_new     (lam_new),
        .lam_control (lam_control),
        .alu_addr    (alu_addr),
        .store_data  (store_data),
        .busy        (busy),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_en       (wb_en),
        .wb_sel      (wb_sel),
        .wb_data     (wb_data),
        .lam_err     (lam_err)
    );

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        bit          chk_wdata;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        bit          is_err;
        logic [4:0]  sel;
        logic [31:0] data;
    } rsp_exp_t;

    mem_exp_t exp_mem[$];
    rsp_exp_t exp_rsp[$];
    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit m_valid(input bit st, input logic [2:0] f3, input logic [31:0] a);
        bit legal;
        if (st) legal = (f3 inside {3'd0, 3'd1, 3'd2});
        else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b0;
        return (a % size_bytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int mask;
        mask = ((1 << size_bytes(f3)) - 1) << (a % 4);
        return mask[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (size_bytes(f3))
            1:       return (d & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (d & 32'h0000_FFFF) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [63:0] raw, v, span;
        int          nbits;
        nbits = 8 * size_bytes(f3);
        span  = 64'd1 << nbits;
        raw   = {32'h0, rd};
        v     = (raw >> (8 * (a % 4))) & (span - 1);
        if (f3[2] == 1'b0 && nbits < 32 && v >= (span >> 1)) v = v - span;
        return v[31:0];
    endfunction

    // ---------------- monitor ----------------
    logic        prev_req;
    mem_exp_t    hold_m;
    mem_exp_t    mon_m;
    rsp_exp_t    mon_r;
    logic [4:0]  last_sel;
    logic [31:0] last_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req  = 1'b0;
            last_sel  = 5'd0;
            last_data = 32'h0;
        end else begin
            if (mem_req && !prev_req) begin
                if (exp_mem.size() == 0) begin
                    check("mem_unexpected_req", 1, 0);
                end else begin
                    mon_m = exp_mem.pop_front();
                    check("mem_we", mem_we, mon_m.we);
                    check("mem_addr", mem_addr, mon_m.addr);
                    check("mem_be", mem_be, mon_m.be);
                    if (mon_m.chk_wdata) check("mem_wdata", mem_wdata, mon_m.wdata);
                end
                hold_m.we    = mem_we;
                hold_m.addr  = mem_addr;
                hold_m.be    = mem_be;
                hold_m.wdata = mem_wdata;
            end else if (mem_req) begin
                check("mem_hold_addr", mem_addr, hold_m.addr);
                check("mem_hold_we_be", {mem_we, mem_be}, {hold_m.we, hold_m.be});
                check("mem_hold_wdata", mem_wdata, hold_m.wdata);
            end
            prev_req = mem_req;

            if (wb_en) begin
                if (exp_rsp.size() == 0) begin
                    check("wb_unexpected", 1, 0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("wb_kind_is_err", 0, mon_r.is_err);
                    check("wb_sel", wb_sel, mon_r.sel);
                    check("wb_data", wb_data, mon_r.data);
                end
                last_sel  = wb_sel;
                last_data = wb_data;
            end else begin
                check("wb_sel_hold", wb_sel, last_sel);
                check("wb_data_hold", wb_data, last_data);
            end

            if (lam_err) begin
                if (exp_rsp.size() == 0) begin
                    check("err_unexpected", 1, 0);
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("err_kind_is_err", 1, mon_r.is_err);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_wait_expired", busy, 0);
    endtask

    task automatic run_cmd(input bit st, input logic [2:0] f3, input logic [4:0] idx,
                           input logic [31:0] addr, input logic [31:0] sdata,
                           input int waits, input logic [31:0] rdata,
                           input bit poke, input bit stray);
        bit       ok;
        int       req_cycles;
        int       exp_cycles;
        mem_exp_t me;
        rsp_exp_t re;
        wait_idle();
        ok = m_valid(st, f3, addr);
        re.is_err = 1'b0;
        re.sel    = idx;
        re.data   = 32'h0;
        if (!ok) begin
            re.is_err = 1'b1;
            exp_rsp.push_back(re);
        end else begin
            me.we        = st;
            me.addr      = addr & ~32'h3;
            me.be        = m_be(f3, addr);
            me.chk_wdata = st;
            me.wdata     = m_wdata(f3, sdata);
            exp_mem.push_back(me);
            if (waits >= TMO) begin
                re.is_err = 1'b1;
                exp_rsp.push_back(re);
            end else if (!st && idx != 5'd0) begin
                re.data = m_load(f3, addr, rdata);
                exp_rsp.push_back(re);
            end
        end
        lam_new     = 1'b1;
        lam_control = {st, f3, idx};
        alu_addr    = addr;
        store_data  = sdata;
        @(negedge clk);
        lam_new     = 1'b0;
        lam_control = 9'($urandom);
        alu_addr    = $urandom;
        store_data  = $urandom;
        if (!ok) begin
            check("inv_busy", busy, 0);
            check("inv_req", mem_req, 0);
            @(negedge clk);
            check("inv_busy2", busy, 0);
            check("inv_req2", mem_req, 0);
        end else begin
            req_cycles = 0;
            while (mem_req === 1'b1 && req_cycles < 4 * TMO + 8) begin
                req_cycles++;
                if (poke && req_cycles == 1) begin
                    lam_new     = 1'b1;
                    lam_control = {1'b1, 3'b010, 5'd1};
                    alu_addr    = 32'h0000_0040;
                end
                if (req_cycles == waits + 1) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                @(negedge clk);
                lam_new   = 1'b0;
                mem_ack   = 1'b0;
                mem_rdata = $urandom;
            end
            exp_cycles = (waits >= TMO) ? TMO : waits + 1;
            check("req_cycles", req_cycles, exp_cycles);
            if (stray) begin
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
            end
        end
    endtask

    // ---------------- stimulus ----------------
    logic        r_st;
    logic [2:0]  r_f3;
    logic [4:0]  r_idx;
    logic [31:0] r_addr;
    int          r_waits;
    mem_exp_t    rst_me;

    initial begin
        rst_n       = 1'b0;
        lam_new     = 1'b0;
        lam_control = 9'h0;
        alu_addr    = 32'h0;
        store_data  = 32'h0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_wb_en", wb_en, 0);
        check("rst_wb_sel", wb_sel, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_lam_err", lam_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW, two wait states
        run_cmd(1'b0, 3'b010, 5'd5, 32'h0000_0100, 32'h0, 2, 32'hDEAD_BEEF, 1'b0, 1'b0);
        // LB / LBU from the top byte lane
        run_cmd(1'b0, 3'b000, 5'd6, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234, 1'b0, 1'b0);
        run_cmd(1'b0, 3'b100, 5'd7, 32'h0000_0103, 32'h0, 1, 32'h80FF_1234, 1'b0, 1'b0);
        // LH / LHU upper half
        run_cmd(1'b0, 3'b001, 5'd8, 32'h0000_0202, 32'h0, 0, 32'h9ABC_1234, 1'b0, 1'b1);
        run_cmd(1'b0, 3'b101, 5'd9, 32'h0000_0202, 32'h0, 0, 32'h9ABC_1234, 1'b0, 1'b0);
        // SH to upper half, SB, SW
        run_cmd(1'b1, 3'b001, 5'd3, 32'h0000_0202, 32'h0000_ABCD, 1, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b1, 3'b000, 5'd3, 32'h0000_0301, 32'h1234_56A5, 0, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b1, 3'b010, 5'd3, 32'h0000_0304, 32'hCAFE_F00D, 3, 32'h0, 1'b0, 1'b0);
        // misaligned and illegal encodings
        run_cmd(1'b0, 3'b010, 5'd4, 32'h0000_0101, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 3'b001, 5'd4, 32'h0000_0103, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b1, 3'b100, 5'd4, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        run_cmd(1'b0, 3'b011, 5'd4, 32'h0000_0100, 32'h0, 0, 32'h0, 1'b0, 1'b0);
        // no ack: timeout; ack on the last waiting cycle: ack wins
        run_cmd(1'b0, 3'b010, 5'd10, 32'h0000_0400, 32'h0, 100, 32'h0, 1'b0, 1'b1);
        run_cmd(1'b0, 3'b010, 5'd11, 32'h0000_0404, 32'h0, TMO - 1, 32'h1357_9BDF, 1'b0, 1'b0);
        // lam_new while busy, load to x0
        run_cmd(1'b0, 3'b010, 5'd12, 32'h0000_0500, 32'h0, 2, 32'h0BAD_F00D, 1'b1, 1'b0);
        run_cmd(1'b0, 3'b010, 5'd0, 32'h0000_0504, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // reset in the middle of a request
        wait_idle();
        rst_me.we        = 1'b0;
        rst_me.addr      = 32'h0000_0300;
        rst_me.be        = 4'b1111;
        rst_me.chk_wdata = 1'b0;
        rst_me.wdata     = 32'h0;
        exp_mem.push_back(rst_me);
        lam_new     = 1'b1;
        lam_control = {1'b0, 3'b010, 5'd7};
        alu_addr    = 32'h0000_0300;
        @(negedge clk);
        lam_new = 1'b0;
        check("rst_mid_req_before", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_req_async", mem_req, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_wb_en", wb_en, 0);
        exp_mem.delete();
        exp_rsp.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_cmd(1'b0, 3'b010, 5'd13, 32'h0000_0600, 32'h0, 1, 32'h2468_ACE0, 1'b0, 1'b0);

        // random commands
        for (int i = 0; i < 300; i++) begin
            r_st    = 1'($urandom_range(0, 1));
            r_f3    = 3'($urandom_range(0, 7));
            r_idx   = 5'($urandom_range(0, 31));
            r_addr  = $urandom;
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            r_waits = $urandom_range(0, TMO + 1);
            run_cmd(r_st, r_f3, r_idx, r_addr, $urandom, r_waits, $urandom,
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("mem_queue_drained", exp_mem.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
